read_reg_status_mipi: RTL and testbench
=======================================

READ_REG_STATUS_MIPI -- requirements
Module: read_reg_status_mipi

Interface
REQ-001 SHALL have parameter ADDR_DECODER_WIDTH, default 8, giving the number of low address bits decoded.
REQ-002 SHALL have parameter CTRL_REG_WIDTH, default 8, giving the width of the control register.
REQ-003 SHALL have parameter INT_WIDTH, default 4, giving the number of interrupt sources.
REQ-004 SHALL have parameter IP_VERSION, default 32'h0001_0000, giving the version word returned on read.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port mem_rd_req, input, 1 bit: read request strobe.
REQ-008 SHALL have port mem_rd_addr, input, 32 bits: read address, sampled when mem_rd_req=1.
REQ-009 SHALL have port mem_rd_valid, output, 1 bit: read data valid.
REQ-010 SHALL have port mem_rd_data, output, 32 bits: read data.
REQ-011 SHALL have port ctrl_reg, input, CTRL_REG_WIDTH bits: control register from the write decoder; bit0 = enable, bit1 = frame-counter clear pulse.
REQ-012 SHALL have port glbl_int_en, input, 1 bit: global interrupt enable.
REQ-013 SHALL have port int_en, input, INT_WIDTH bits: per-source interrupt enables.
REQ-014 SHALL have port int_status_clr, input, INT_WIDTH bits: write-1-to-clear pulses.
REQ-015 SHALL have port int_event, input, INT_WIDTH bits: single-cycle event pulses from the datapath.
REQ-016 SHALL have port frame_end, input, 1 bit: end-of-frame pulse.
REQ-017 SHALL have port interrupt_o, output, 1 bit: level interrupt to the CPU.

Function
REQ-018 SHALL decode the following offsets on mem_rd_addr[ADDR_DECODER_WIDTH-1:0]: 0x00 VERSION, 0x04 CTRL_REG, 0x08 GLBL_INT_EN, 0x0C INT_STATUS, 0x10 INT_EN, 0x14 FRAME_CNT.
REQ-019 SHALL drive mem_rd_valid=1 exactly one cycle after each cycle in which mem_rd_req=1, and 0 otherwise; back-to-back requests on consecutive cycles SHALL produce consecutive valid cycles with no stall.
REQ-020 SHALL register mem_rd_data together with mem_rd_valid, holding the value of the addressed register as it was on the request cycle (i.e. before any update in that same cycle); narrower registers SHALL be zero-extended.
REQ-021 SHALL return 32'h0 for unmapped offsets and SHALL hold mem_rd_data at its last value while mem_rd_valid=0.
REQ-022 SHALL NOT cause any register side effect from a read; INT_STATUS is cleared only by int_status_clr.
REQ-023 SHALL hold a sticky int_status[i] that is set on int_event[i]=1 and cleared on int_status_clr[i]=1; when both occur in the same cycle, set SHALL win.
REQ-024 SHALL set int_status regardless of int_en; int_en gates only the interrupt.
REQ-025 SHALL register interrupt_o = glbl_int_en & |(int_status & int_en), updating one cycle after int_status, int_en or glbl_int_en changes.
REQ-026 SHALL keep a 32-bit frame_cnt that increments by 1 on frame_end=1 when ctrl_reg[0]=1, and wraps from 0xFFFF_FFFF to 0.
REQ-027 SHALL zero frame_cnt when ctrl_reg[1]=1; clear SHALL take priority over a same-cycle increment.
REQ-028 SHALL read the CTRL_REG, GLBL_INT_EN and INT_EN offsets directly from the corresponding input ports.

Reset
REQ-029 SHALL, on any rising edge of aclk with aresetn=0, force mem_rd_valid=0, mem_rd_data=0, int_status=0, frame_cnt=0 and interrupt_o=0.
REQ-030 SHALL discard a read request accepted in the cycle before reset asserts; no mem_rd_valid SHALL follow it.
REQ-031 SHALL ignore int_event and frame_end while aresetn=0.

Verification
REQ-032 SHALL be verified for read of VERSION: mem_rd_req=1, addr=0x00 -> next cycle mem_rd_valid=1, mem_rd_data=0x0001_0000.
REQ-033 SHALL be verified for back-to-back reads: requests on 3 consecutive cycles to 0x00, 0x3C, 0x10 (int_en=4'b0101) -> 3 consecutive valid cycles with data 0x0001_0000, 0x0, 0x5.
REQ-034 SHALL be verified for the interrupt path: int_en=4'b0010, glbl_int_en=1, pulse int_event[1] -> INT_STATUS reads 0x2 and interrupt_o=1 two cycles after the event; int_status_clr=4'b0010 -> interrupt_o=0 two cycles later.
REQ-035 SHALL be verified for simultaneous set and clear: int_event[0] and int_status_clr[0] in the same cycle -> INT_STATUS bit0 remains 1.
REQ-036 SHALL be verified for frame-counter wrap and clear: counter preloaded to 0xFFFF_FFFF, ctrl_reg[0]=1, frame_end -> FRAME_CNT reads 0; frame_end together with ctrl_reg[1] -> FRAME_CNT reads 0.
REQ-037 SHALL be verified for mid-read reset: mem_rd_req then aresetn=0 on the next edge -> mem_rd_valid stays 0 and all outputs are 0.

Source files
------------

// File: rtl/read_reg_status_mipi.sv
// Read-side register block for the MIPI receiver: version/control/interrupt/frame
// registers on a one-cycle read port, sticky interrupt status and a frame counter.
module read_reg_status_mipi #(
    parameter int          ADDR_DECODER_WIDTH = 8,
    parameter int          CTRL_REG_WIDTH     = 8,
    parameter int          INT_WIDTH          = 4,
    parameter logic [31:0] IP_VERSION         = 32'h0001_0000
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          mem_rd_req,
    input  logic [31:0]                   mem_rd_addr,
    output logic                          mem_rd_valid,
    output logic [31:0]                   mem_rd_data,
    input  logic [CTRL_REG_WIDTH-1:0]     ctrl_reg,
    input  logic                          glbl_int_en,
    input  logic [INT_WIDTH-1:0]          int_en,
    input  logic [INT_WIDTH-1:0]          int_status_clr,
    input  logic [INT_WIDTH-1:0]          int_event,
    input  logic                          frame_end,
    output logic                          interrupt_o
);

    localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_VERSION     = ADDR_DECODER_WIDTH'('h00);
    localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_CTRL_REG    = ADDR_DECODER_WIDTH'('h04);
    localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_GLBL_INT_EN = ADDR_DECODER_WIDTH'('h08);
    localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_INT_STATUS  = ADDR_DECODER_WIDTH'('h0C);
    localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_INT_EN      = ADDR_DECODER_WIDTH'('h10);
    localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_FRAME_CNT   = ADDR_DECODER_WIDTH'('h14);

    logic                          mem_rd_valid_q, mem_rd_valid_d;
    logic [31:0]                   mem_rd_data_q,  mem_rd_data_d;
    logic [INT_WIDTH-1:0]          int_status_q,   int_status_d;
    logic                          interrupt_q,    interrupt_d;
    logic [31:0]                   frame_cnt_q,    frame_cnt_d;

    logic [ADDR_DECODER_WIDTH-1:0] rd_offset;
    logic [31:0]                   rd_mux;
    logic                          unused_addr_bits;

    assign rd_offset        = mem_rd_addr[ADDR_DECODER_WIDTH-1:0];
    assign unused_addr_bits = ^mem_rd_addr[31:ADDR_DECODER_WIDTH];

    // Read mux sees the registered (pre-update) values, so a read returns the
    // register as it stood on the request cycle.
    always_comb begin
        rd_mux = '0;
        case (rd_offset)
            OFF_VERSION:     rd_mux = IP_VERSION;
            OFF_CTRL_REG:    rd_mux[CTRL_REG_WIDTH-1:0] = ctrl_reg;
            OFF_GLBL_INT_EN: rd_mux[0] = glbl_int_en;
            OFF_INT_STATUS:  rd_mux[INT_WIDTH-1:0] = int_status_q;
            OFF_INT_EN:      rd_mux[INT_WIDTH-1:0] = int_en;
            OFF_FRAME_CNT:   rd_mux = frame_cnt_q;
            default:         rd_mux = '0;
        endcase
    end

    // Read port: mem_rd_valid is a one-cycle pulse exactly one cycle after each
    // mem_rd_req; there is no back-pressure and mem_rd_data holds between pulses.
    always_comb begin
        mem_rd_valid_d = mem_rd_req;
        mem_rd_data_d  = mem_rd_data_q;
        if (mem_rd_req) begin
            mem_rd_data_d = rd_mux;
        end
    end

    always_comb begin
        int_status_d = (int_status_q & ~int_status_clr) | int_event;
        interrupt_d  = glbl_int_en & (|(int_status_q & int_en));
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (ctrl_reg[1]) begin
            frame_cnt_d = '0;
        end else if (ctrl_reg[0] && frame_end) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mem_rd_valid_q <= 1'b0;
            mem_rd_data_q  <= '0;
            int_status_q   <= '0;
            interrupt_q    <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            mem_rd_valid_q <= mem_rd_valid_d;
            mem_rd_data_q  <= mem_rd_data_d;
            int_status_q   <= int_status_d;
            interrupt_q    <= interrupt_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign mem_rd_valid = mem_rd_valid_q;
    assign mem_rd_data  = mem_rd_data_q;
    assign interrupt_o  = interrupt_q;

endmodule

// File: tb/tb_read_reg_status_mipi.sv
// Self-checking bench for read_reg_status_mipi: table of reads plus hand-written
// interrupt, frame-counter and reset sequences, checked through an expected queue.
module tb_read_reg_status_mipi;

    logic        aclk;
    logic        aresetn;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic [7:0]  ctrl_reg;
    logic        glbl_int_en;
    logic [3:0]  int_en;
    logic [3:0]  int_status_clr;
    logic [3:0]  int_event;
    logic        frame_end;
    logic        interrupt_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic        exp_valid_nxt = 1'b0;
    logic        rst_edge      = 1'b0;
    logic [31:0] last_exp      = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    read_reg_status_mipi dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .mem_rd_req     (mem_rd_req),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .ctrl_reg       (ctrl_reg),
        .glbl_int_en    (glbl_int_en),
        .int_en         (int_en),
        .int_status_clr (int_status_clr),
        .int_event      (int_event),
        .frame_end      (frame_end),
        .interrupt_o    (interrupt_o)
    );

    // clock / reset block
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // scoreboard: valid must follow every sampled request by one cycle
    always @(posedge aclk) begin
        exp_valid_nxt <= aresetn && mem_rd_req;
        rst_edge      <= !aresetn;
    end

    always @(negedge aclk) begin
        if (rst_edge) last_exp = 32'h0;
        check("rd_valid", {31'h0, mem_rd_valid}, {31'h0, exp_valid_nxt});
        if (mem_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", {31'h0, mem_rd_valid}, 32'h0);
            end else begin
                last_exp = exp_q.pop_front();
                check("rd_data", mem_rd_data, last_exp);
            end
        end else begin
            check("rd_hold", mem_rd_data, last_exp);
        end
    end

    // driver tasks: inputs change just after the falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge aclk);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        mem_rd_req  = 1'b1;
        mem_rd_addr = addr;
        exp_q.push_back(exp);
        @(negedge aclk);
        mem_rd_req  = 1'b0;
        mem_rd_addr = $urandom_range(0, 255);
    endtask

    initial begin
        aresetn = 1'b0; mem_rd_req = 1'b0; mem_rd_addr = 32'h0;
        ctrl_reg = 8'h81; glbl_int_en = 1'b1; int_en = 4'b0101;
        int_status_clr = 4'h0; int_event = 4'h0; frame_end = 1'b0;

        tbl[0] = '{32'h0000_0000, 32'h0001_0000};
        tbl[1] = '{32'h0000_003C, 32'h0000_0000};
        tbl[2] = '{32'h0000_0010, 32'h0000_0005};
        tbl[3] = '{32'h0000_0004, 32'h0000_0081};
        tbl[4] = '{32'h0000_0008, 32'h0000_0001};
        tbl[5] = '{32'h0000_000C, 32'h0000_0000};
        tbl[6] = '{32'h0000_0014, 32'h0000_0000};
        tbl[7] = '{32'h0000_0018, 32'h0000_0000};
        tbl[8] = '{32'hABCD_0100, 32'h0001_0000};
        tbl[9] = '{32'h0000_0002, 32'h0000_0000};

        step(3);
        aresetn = 1'b1;
        check("reset_valid", {31'h0, mem_rd_valid}, 32'h0);
        check("reset_data", mem_rd_data, 32'h0);
        check("reset_irq", {31'h0, interrupt_o}, 32'h0);
        step(1);

        for (int i = 0; i < 10; i++) rd(tbl[i].addr, tbl[i].exp);
        step(2);

        // interrupt path through int_en bit 1
        int_en = 4'b0010;
        int_event = 4'b0010; step(1); int_event = 4'h0;
        check("irq_after_1", {31'h0, interrupt_o}, 32'h0);
        step(1);
        check("irq_after_2", {31'h0, interrupt_o}, 32'h1);
        rd(32'h0C, 32'h2);
        int_status_clr = 4'b0010; step(1); int_status_clr = 4'h0;
        check("irq_clr_1", {31'h0, interrupt_o}, 32'h1);
        step(1);
        check("irq_clr_2", {31'h0, interrupt_o}, 32'h0);
        rd(32'h0C, 32'h0);

        // status set while its enable is off: sticky but no interrupt
        int_event = 4'b1000; step(1); int_event = 4'h0;
        step(2);
        check("irq_masked", {31'h0, interrupt_o}, 32'h0);
        rd(32'h0C, 32'h8);
        int_status_clr = 4'b1000; step(1); int_status_clr = 4'h0;

        // simultaneous set and clear on bit 0
        int_event = 4'b0001; step(1);
        int_status_clr = 4'b0001; step(1);
        int_event = 4'h0; int_status_clr = 4'h0;
        rd(32'h0C, 32'h1);

        // read in the same cycle as an event returns the pre-update value
        int_event = 4'b0100;
        rd(32'h0C, 32'h1);
        int_event = 4'h0;
        rd(32'h0C, 32'h5);

        // global enable gating
        int_en = 4'b0011; step(2);
        check("irq_glbl_on", {31'h0, interrupt_o}, 32'h1);
        glbl_int_en = 1'b0; step(1);
        check("irq_glbl_off", {31'h0, interrupt_o}, 32'h0);
        glbl_int_en = 1'b1; step(1);

        // frame counter: enable, disabled pulse, wrap, clear priority
        ctrl_reg = 8'h01;
        for (int i = 0; i < 3; i++) begin
            frame_end = 1'b1; step(1); frame_end = 1'b0; step($urandom_range(0, 2));
        end
        rd(32'h14, 32'h3);
        ctrl_reg = 8'h00; frame_end = 1'b1; step(1); frame_end = 1'b0;
        rd(32'h14, 32'h3);
        ctrl_reg = 8'h01;
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        step(1);
        release dut.frame_cnt_q;
        rd(32'h14, 32'hFFFF_FFFF);
        frame_end = 1'b1; step(1); frame_end = 1'b0;
        rd(32'h14, 32'h0);
        frame_end = 1'b1; step(1);
        ctrl_reg = 8'h03; step(1); frame_end = 1'b0; ctrl_reg = 8'h01;
        rd(32'h14, 32'h0);
        frame_end = 1'b1; step(1); frame_end = 1'b0;
        check("irq_pre_reset", {31'h0, interrupt_o}, 32'h1);

        // request on the same edge that samples reset: no valid follows
        mem_rd_req = 1'b1; mem_rd_addr = 32'h0; aresetn = 1'b0;
        step(1);
        mem_rd_req = 1'b0;
        check("rst_valid", {31'h0, mem_rd_valid}, 32'h0);
        check("rst_data", mem_rd_data, 32'h0);
        check("rst_irq", {31'h0, interrupt_o}, 32'h0);
        int_event = 4'hF; frame_end = 1'b1; step(2);
        int_event = 4'h0; frame_end = 1'b0; aresetn = 1'b1;
        check("rst_valid_hold", {31'h0, mem_rd_valid}, 32'h0);
        step(1);
        rd(32'h0C, 32'h0);
        rd(32'h14, 32'h0);
        step(3);

        check("queue_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
